aes_enc_arbiter: RTL

//  Shares one aes_encipher_block core between NUM_REQ requesters. Picks one request round-robin,

---
 rtl/aes_enc_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/aes_enc_arbiter.sv
// Round-robin arbiter sharing one aes_encipher_block core between NUM_REQ requesters.
// Define AES_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module aes_enc_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_keylen,
    input  logic [NUM_REQ*128-1:0]   req_block,
    output logic [NUM_REQ-1:0]       ack,
    output logic [127:0]             result,
    output logic                     result_valid,
    output logic                     busy,
    output logic [IDX_W-1:0]         key_sel,
    output logic                     core_next,
    output logic                     core_keylen,
    output logic [127:0]             core_block,
    input  logic                     core_ready,
    input  logic [127:0]             core_result
);

    // IDLE: arbitrate | START: pulse core_next | BUSY: wait core_ready | DONE: ack + result_valid
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W:0]   cand_sum;
    logic             grant_found;

    // Scan from the highest offset down so the nearest set bit at/after rr_ptr wins last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = cand_sum[IDX_W-1:0];
            if (req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b1;
        core_next    = 1'b0;
        result_valid = 1'b0;
        ack          = '0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (grant_found) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                core_next = 1'b1;
                state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (core_ready) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                result_valid = 1'b1;
                ack          = NUM_REQ'(1) << key_sel;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_sel     <= '0;
            core_block  <= '0;
            core_keylen <= 1'b0;
            result      <= '0;
        end else begin
            if (state == ST_IDLE && grant_found) begin
                key_sel     <= grant_idx;
                core_block  <= req_block[grant_idx*128 +: 128];
                core_keylen <= req_keylen[grant_idx];
            end
            if (state == ST_BUSY && core_ready) begin
                result <= core_result;
            end
        end
    end

`ifdef AES_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == ST_DONE) begin
            rr_ptr <= (key_sel == IDX_W'(NUM_REQ - 1)) ? '0 : key_sel + IDX_W'(1);
        end
    end
`endif

endmodule
